// File: rtl/matvec_loader.sv
// matvec_loader: parses a {vdim, hdim} header, loads hdim vector bytes into SRAM, then forwards vdim*hdim matrix bytes to matmul.
// Ports: clk/rst; s_* upstream byte stream; m_* matrix stream; vdim/hdim job dimensions; mm_rst matmul reset;
//        vec_sram_* vector SRAM write port; sram_own SRAM ownership; busy/done/err status;
//        job_count (only with MATVEC_LOADER_STATS_EN) counts completed jobs.
module matvec_loader #(
  parameter int MAX_DIM = 16,
  parameter int SRAM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [7:0]                 m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [7:0]                 vdim,
  output logic [7:0]                 hdim,
  output logic                       mm_rst,
  output logic                       vec_sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0] vec_sram_addr,
  output logic [7:0]                 vec_sram_din,
  output logic                       sram_own,
  output logic                       busy,
  output logic                       done,
  output logic                       err
`ifdef MATVEC_LOADER_STATS_EN
  ,
  output logic [15:0]                job_count
`endif
);
  typedef enum logic [2:0] {HDR_V, HDR_H, LOAD_VEC, ARM, STREAM, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] vdim_q, vdim_d, hdim_q, hdim_d, col_q, col_d, row_q, row_d, din_q, din_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic we_q, we_d, err_q, err_d, xfer, col_last, bad;
  assign s_ready = (state_q == STREAM) ? m_ready : (state_q == HDR_V || state_q == HDR_H || state_q == LOAD_VEC);
  assign xfer = s_valid && s_ready;
  assign col_last = col_q == hdim_q - 8'd1;
  assign bad = vdim_q == 8'd0 || s_data == 8'd0 || int'(s_data) > MAX_DIM;
  assign m_data = s_data;
  assign m_valid = state_q == STREAM && s_valid;
  assign mm_rst = state_q != STREAM;
  assign sram_own = state_q != STREAM;
  assign busy = state_q != HDR_V;
  assign done = state_q == DONE;
  assign vdim = vdim_q;
  assign hdim = hdim_q;
  assign vec_sram_we = we_q;
  assign vec_sram_addr = addr_q;
  assign vec_sram_din = din_q;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    vdim_d = vdim_q;
    hdim_d = hdim_q;
    col_d = col_q;
    row_d = row_q;
    we_d = 1'b0;
    addr_d = addr_q;
    din_d = din_q;
    err_d = err_q;
    case (state_q)
      HDR_V: if (xfer) begin
        vdim_d = s_data;
        state_d = HDR_H;
      end
      HDR_H: if (xfer) begin
        hdim_d = s_data;
        err_d = err_q | bad;
        state_d = bad ? HDR_V : LOAD_VEC;
      end
      LOAD_VEC: if (xfer) begin
        we_d = 1'b1;
        addr_d = SRAM_ADDR_WIDTH'(col_q);
        din_d = s_data;
        col_d = col_last ? 8'd0 : col_q + 8'd1;
        state_d = col_last ? ARM : LOAD_VEC;
      end
      ARM: state_d = STREAM;
      STREAM: if (xfer) begin
        col_d = col_last ? 8'd0 : col_q + 8'd1;
        row_d = col_last ? ((row_q == vdim_q - 8'd1) ? 8'd0 : row_q + 8'd1) : row_q;
        state_d = (col_last && row_q == vdim_q - 8'd1) ? DONE : STREAM;
      end
      default: state_d = HDR_V;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR_V;
      vdim_q <= '0;
      hdim_q <= '0;
      col_q <= '0;
      row_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vdim_q <= vdim_d;
      hdim_q <= hdim_d;
      col_q <= col_d;
      row_q <= row_d;
      we_q <= we_d;
      addr_q <= addr_d;
      din_q <= din_d;
      err_q <= err_d;
    end
  end
`ifdef MATVEC_LOADER_STATS_EN
  logic [15:0] job_count_q, job_count_d;
  assign job_count_d = (state_q == DONE) ? job_count_q + 16'd1 : job_count_q;
  assign job_count = job_count_q;
  always_ff @(posedge clk) job_count_q <= rst ? 16'd0 : job_count_d;
`endif
endmodule
